// File: rtl/repeat_id_gen.sv
// rtl/repeat_id_gen.sv - streams every ID in [lo, hi] made of one digit block repeated GROUP_N times
// Emits IDs in ascending order per digit count d, keeping a running count and sum of accepted IDs.
module repeat_id_gen #(
    parameter int GROUP_N = 2,
    parameter int DW      = 64,
    parameter int SUM_W   = 128
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DW-1:0]    lo,
    input  logic [DW-1:0]    hi,
    output logic             busy,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [DW-1:0]    id_out,
    output logic             done,
    output logic [31:0]      id_count,
    output logic [SUM_W-1:0] id_sum
);
    localparam int KW = $clog2(GROUP_N + 1);
    localparam logic [5:0] GN = 6'(GROUP_N);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REP, S_BOUND, S_EMIT, S_DONE} state_t;

    state_t        state;
    logic [DW-1:0] lo_r;
    logic [DW-1:0] hi_r;
    logic [DW-1:0] rep;
    logic [DW-1:0] p10b;
    logic [DW-1:0] p10b_m1;
    logic [DW-1:0] m_cur;
    logic [DW-1:0] m_end;
    logic [5:0]    d;
    logic [5:0]    hi_d;
    logic [KW-1:0] k;

    // Decimal digit count; the comparison ladder is kept a byte wider so 10^20 never wraps.
    function automatic logic [5:0] digits(input logic [DW-1:0] x);
        logic [DW+7:0] p;
        logic [5:0]    n;
        n = 6'd1;
        p = (DW+8)'(10);
        for (int i = 2; i <= 20; i++) begin
            if ({8'd0, x} >= p)
                n = 6'(i);
            p = p * (DW+8)'(10);
        end
        return n;
    endfunction

    function automatic logic [DW-1:0] pow10(input logic [5:0] e);
        logic [DW-1:0] r;
        r = DW'(1);
        for (int i = 0; i < 20; i++) begin
            if (6'(i) < e)
                r = r * DW'(10);
        end
        return r;
    endfunction

    logic [DW-1:0] lo_eff;
    logic [DW-1:0] q_lo;
    logic [DW-1:0] q_hi;
    logic [DW-1:0] m_lo_c;
    logic [DW-1:0] m_hi_c;
    logic [5:0]    b_c;

    assign lo_eff = (lo == '0) ? DW'(1) : lo;
    assign b_c    = d / GN;
    // Multiplier window for this d: [10^(b-1), 10^b-1] clipped to ceil(lo/rep)..floor(hi/rep).
    assign q_lo   = (lo_r / rep) + (((lo_r % rep) != '0) ? DW'(1) : '0);
    assign q_hi   = hi_r / rep;
    assign m_lo_c = (q_lo > p10b_m1) ? q_lo : p10b_m1;
    assign m_hi_c = (q_hi < (p10b - DW'(1))) ? q_hi : (p10b - DW'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            id_valid <= 1'b0;
            done     <= 1'b0;
            id_out   <= '0;
            id_count <= '0;
            id_sum   <= '0;
            lo_r     <= '0;
            hi_r     <= '0;
            rep      <= '0;
            p10b     <= '0;
            p10b_m1  <= '0;
            m_cur    <= '0;
            m_end    <= '0;
            d        <= '0;
            hi_d     <= '0;
            k        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lo_r     <= lo_eff;
                        hi_r     <= hi;
                        hi_d     <= digits(hi);
                        d        <= digits(lo_eff);
                        id_count <= '0;
                        id_sum   <= '0;
                        busy     <= 1'b1;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if ((lo_r > hi_r) || (d > hi_d)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if ((d % GN) != 6'd0) begin
                        d <= d + 6'd1;
                    end else begin
                        p10b    <= pow10(b_c);
                        p10b_m1 <= pow10(b_c - 6'd1);
                        rep     <= '0;
                        k       <= '0;
                        state   <= S_REP;
                    end
                end
                S_REP: begin
                    rep <= rep * p10b + DW'(1);
                    k   <= k + KW'(1);
                    if (k == KW'(GROUP_N - 1))
                        state <= S_BOUND;
                end
                S_BOUND: begin
                    if (m_lo_c > m_hi_c) begin
                        d     <= d + 6'd1;
                        state <= S_SCAN;
                    end else begin
                        m_cur    <= m_lo_c;
                        m_end    <= m_hi_c;
                        id_out   <= m_lo_c * rep;
                        id_valid <= 1'b1;
                        state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (id_ready) begin
                        id_count <= id_count + 32'd1;
                        id_sum   <= id_sum + SUM_W'(id_out);
                        if (m_cur == m_end) begin
                            id_valid <= 1'b0;
                            d        <= d + 6'd1;
                            state    <= S_SCAN;
                        end else begin
                            m_cur  <= m_cur + DW'(1);
                            id_out <= id_out + rep;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_repeat_id_gen.sv
// tb/tb_repeat_id_gen.sv - self-checking bench for repeat_id_gen against a brute-force digit model
module tb_repeat_id_gen;
    logic         clock;
    logic         reset;
    logic         start2;
    logic         start3;
    logic [63:0]  lo;
    logic [63:0]  hi;
    logic         id_ready;
    logic         busy2, valid2, done2, busy3, valid3, done3;
    logic [63:0]  out2, out3;
    logic [31:0]  cnt2, cnt3;
    logic [127:0] sum2, sum3;

    logic         sel;
    logic         obs_busy, obs_valid, obs_done;
    logic [63:0]  obs_id;
    logic [31:0]  obs_cnt;
    logic [127:0] obs_sum;

    int total = 0;
    int bad   = 0;

    repeat_id_gen #(.GROUP_N(2), .DW(64), .SUM_W(128)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .lo(lo), .hi(hi),
        .busy(busy2), .id_valid(valid2), .id_ready(id_ready), .id_out(out2),
        .done(done2), .id_count(cnt2), .id_sum(sum2)
    );

    repeat_id_gen #(.GROUP_N(3), .DW(64), .SUM_W(128)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .lo(lo), .hi(hi),
        .busy(busy3), .id_valid(valid3), .id_ready(id_ready), .id_out(out3),
        .done(done3), .id_count(cnt3), .id_sum(sum3)
    );

    assign obs_busy  = sel ? busy3  : busy2;
    assign obs_valid = sel ? valid3 : valid2;
    assign obs_done  = sel ? done3  : done2;
    assign obs_id    = sel ? out3   : out2;
    assign obs_cnt   = sel ? cnt3   : cnt2;
    assign obs_sum   = sel ? sum3   : sum2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // True when the decimal string of v is one block repeated exactly g times.
    function automatic bit is_rep(input logic [63:0] v, input int g);
        int dig[20];
        int n;
        int b;
        n = 0;
        while (v != 64'd0) begin
            dig[n] = int'(v % 64'd10);
            v = v / 64'd10;
            n++;
        end
        if (n == 0 || (n % g) != 0)
            return 1'b0;
        b = n / g;
        for (int i = b; i < n; i++)
            if (dig[i] != dig[i % b])
                return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_job(input string tag, input bit s, input logic [63:0] lo_v,
                           input logic [63:0] hi_v, input int mode, input int exp_first,
                           input int exp_done, input bit hold);
        logic [63:0]  q[$];
        logic [127:0] esum;
        logic [63:0]  lo1, prev_id, x, exp_id;
        int           first, donecyc, ndone, expn;
        bit           prev_stall, fin;

        q = {};
        esum = '0;
        lo1 = (lo_v == 64'd0) ? 64'd1 : lo_v;
        if (lo1 <= hi_v) begin
            for (x = lo1; x <= hi_v; x++) begin
                if (is_rep(x, s ? 3 : 2)) begin
                    q.push_back(x);
                    esum += 128'(x);
                end
                if (x == hi_v) break;
            end
        end
        expn = q.size();

        @(negedge clock);
        sel = s;
        lo = lo_v;
        hi = hi_v;
        id_ready = 1'b0;
        if (s) start3 = 1'b1; else start2 = 1'b1;
        @(negedge clock);
        if (!hold) begin
            start2 = 1'b0;
            start3 = 1'b0;
        end
        first = -1; donecyc = -1; ndone = 0; prev_stall = 1'b0; prev_id = '0; fin = 1'b0;
        chk({tag, " busy"}, 128'(obs_busy), 128'(1'b1));

        for (int cyc = 1; cyc < 4000 && !fin; cyc++) begin
            if (cyc > 1) @(negedge clock);
            if (obs_valid && first < 0) first = cyc;
            if (prev_stall) begin
                chk({tag, " hold_valid"}, 128'(obs_valid), 128'(1'b1));
                chk({tag, " hold_id"}, 128'(obs_id), 128'(prev_id));
            end
            if (obs_done) begin
                ndone++;
                donecyc = cyc;
                fin = 1'b1;
                start2 = 1'b0;
                start3 = 1'b0;
                id_ready = 1'b0;
            end else begin
                case (mode)
                    0:       id_ready = 1'b1;
                    1:       id_ready = ((cyc % 3) == 0);
                    default: id_ready = 1'($urandom_range(0, 1));
                endcase
                if (obs_valid && id_ready) begin
                    exp_id = (q.size() > 0) ? q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
                    chk({tag, " id"}, 128'(obs_id), 128'(exp_id));
                end
                prev_stall = obs_valid && !id_ready;
                prev_id = obs_id;
            end
        end

        chk({tag, " done_seen"}, 128'(ndone), 128'(1));
        chk({tag, " count"}, 128'(obs_cnt), 128'(expn));
        chk({tag, " sum"}, obs_sum, esum);
        chk({tag, " left"}, 128'(q.size()), 128'(0));
        if (exp_first >= 0)
            chk({tag, " first_valid_cycle"}, 128'(first), 128'(exp_first));
        else if (expn == 0)
            chk({tag, " no_valid"}, 128'(first), 128'(-1));
        if (exp_done >= 0)
            chk({tag, " done_cycle"}, 128'(donecyc), 128'(exp_done));
        @(negedge clock);
        chk({tag, " done_pulse"}, 128'(obs_done), 128'(1'b0));
        chk({tag, " idle"}, 128'(obs_busy), 128'(1'b0));
    endtask

    initial begin
        int          b, g;
        logic [63:0] m, p, x, lo_v, hi_v;

        reset = 1'b1; start2 = 1'b0; start3 = 1'b0; lo = '0; hi = '0; id_ready = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst busy", 128'(busy2), 128'(1'b0));
        chk("rst valid", 128'(valid2), 128'(1'b0));
        chk("rst done", 128'(done2), 128'(1'b0));
        chk("rst id_out", 128'(out2), 128'(0));
        chk("rst count", 128'(cnt2), 128'(0));
        chk("rst sum", sum2, 128'(0));
        chk("rst valid3", 128'(valid3), 128'(1'b0));

        run_job("t11_22", 1'b0, 64'd11, 64'd22, 0, 5, -1, 1'b0);
        run_job("t998", 1'b0, 64'd998, 64'd1012, 0, -1, -1, 1'b0);
        run_job("t1188", 1'b0, 64'd1188511880, 64'd1188511890, 0, -1, -1, 1'b0);
        run_job("t10_99", 1'b0, 64'd10, 64'd99, 1, -1, -1, 1'b0);
        run_job("t100_999", 1'b0, 64'd100, 64'd999, 0, -1, -1, 1'b0);
        run_job("t50_20", 1'b0, 64'd50, 64'd20, 0, -1, 2, 1'b0);
        run_job("hold_start", 1'b0, 64'd11, 64'd33, 2, -1, -1, 1'b1);
        run_job("g3_1_1000", 1'b1, 64'd1, 64'd1000, 0, -1, -1, 1'b0);
        run_job("lo_zero", 1'b0, 64'd0, 64'd60, 2, -1, -1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            g = (t < 4) ? 2 : 3;
            b = $urandom_range(1, (g == 2) ? 4 : 3);
            p = 64'(10 ** b);
            m = 64'($urandom_range(10 ** (b - 1), (10 ** b) - 1));
            x = '0;
            for (int j = 0; j < g; j++) x = x * p + m;
            lo_v = x - 64'($urandom_range(0, (x > 400) ? 400 : 32'(x - 1)));
            hi_v = x + 64'($urandom_range(0, 400));
            run_job("rnd", g == 3, lo_v, hi_v, 2, -1, -1, 1'b0);
        end

        sel = 1'b0;
        @(negedge clock);
        lo = 64'd10; hi = 64'd99; start2 = 1'b1; id_ready = 1'b0;
        @(negedge clock);
        start2 = 1'b0;
        for (int i = 0; i < 20 && !valid2; i++) @(negedge clock);
        chk("mid valid_up", 128'(valid2), 128'(1'b1));
        id_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        id_ready = 1'b0;
        chk("mid count2", 128'(cnt2), 128'(2));
        chk("mid sum2", sum2, 128'(33));
        reset = 1'b1;
        @(negedge clock);
        chk("mid valid", 128'(valid2), 128'(1'b0));
        chk("mid busy", 128'(busy2), 128'(1'b0));
        chk("mid count", 128'(cnt2), 128'(0));
        chk("mid sum", sum2, 128'(0));
        chk("mid id_out", 128'(out2), 128'(0));
        reset = 1'b0;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
